memory_data_arbiter: RTL

Shares the single-port synchronous data memory (1-cycle read latency, write-or-read per cycle) between two requesters.
- Port 0: CPU load/store unit.
- Port 1: debug/DMA loader.
Sits between both requesters and the memory's clk/A/W/D/Q pins. Provides round-robin arbitration, a bounded lock for atomic read-modify-write, and read-return routing.

---
 rtl/memory_data_arbiter_pkg.sv | 22 ++
 rtl/memory_data_arbiter_if.sv | 49 ++++
 rtl/memory_data_arbiter_rr_arbiter2.sv | 44 ++++
 rtl/memory_data_arbiter.sv | 135 +++++++++++++
 4 files changed

// File: rtl/memory_data_arbiter_pkg.sv
// Shared widths, state encoding and port-index constants for the data memory arbiter.
package memory_data_arbiter_pkg;

  localparam int MEM_ADDR      = 8;
  localparam int MEM_DATA_ADDR = MEM_ADDR;
  localparam int LEN_REG       = 32;
  localparam int LOCK_W        = 8;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOCKED = 2'd1
  } arb_state_t;

  // The port that is not p; used to hand priority to the non-owner.
  function automatic logic other_port(input logic p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/memory_data_arbiter_if.sv
// Requester and memory-pin bundle. Handshake: an access completes in the cycle
// where rN_req && rN_gnt; the requester holds req/we/lock/addr/wdata stable until
// granted, and gnt never asserts without req. rN_rvalid is a one-cycle pulse one
// cycle after a granted read, with rN_rdata meaningful only while it is high.
interface memory_data_arbiter_if;
  import memory_data_arbiter_pkg::*;

  logic                r0_req;
  logic                r0_we;
  logic                r0_lock;
  logic [MEM_ADDR-1:0] r0_addr;
  logic [LEN_REG-1:0]  r0_wdata;
  logic                r0_gnt;
  logic                r0_rvalid;
  logic [LEN_REG-1:0]  r0_rdata;

  logic                r1_req;
  logic                r1_we;
  logic                r1_lock;
  logic [MEM_ADDR-1:0] r1_addr;
  logic [LEN_REG-1:0]  r1_wdata;
  logic                r1_gnt;
  logic                r1_rvalid;
  logic [LEN_REG-1:0]  r1_rdata;

  logic [MEM_ADDR-1:0] mem_A;
  logic                mem_W;
  logic [LEN_REG-1:0]  mem_D;
  logic [LEN_REG-1:0]  mem_Q;

  modport slave (
    input  r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
    input  r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
    input  mem_Q,
    output r0_gnt, r0_rvalid, r0_rdata,
    output r1_gnt, r1_rvalid, r1_rdata,
    output mem_A, mem_W, mem_D
  );

  modport master (
    output r0_req, r0_we, r0_lock, r0_addr, r0_wdata,
    output r1_req, r1_we, r1_lock, r1_addr, r1_wdata,
    output mem_Q,
    input  r0_gnt, r0_rvalid, r0_rdata,
    input  r1_gnt, r1_rvalid, r1_rdata,
    input  mem_A, mem_W, mem_D
  );

endinterface

// File: rtl/memory_data_arbiter_rr_arbiter2.sv
// Two-way round-robin grant with a per-port mask and a one-cycle priority override.
module rr_arbiter2
  import memory_data_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req_i,
  input  logic [1:0] mask_i,
  input  logic       prio_force_i,
  input  logic       prio_port_i,
  output logic [1:0] gnt_o,
  output logic       win_o
);

  logic       ptr_q;
  logic       ptr_d;
  logic       prio;
  logic [1:0] eff_req;

  assign eff_req = req_i & mask_i;
  assign prio    = prio_force_i ? prio_port_i : ptr_q;

  // Single eligible requester wins outright; a tie goes to the priority port.
  always_comb begin
    gnt_o = eff_req;
    if (eff_req == 2'b11) gnt_o = (prio == PORT1) ? 2'b10 : 2'b01;
  end

  assign win_o = gnt_o[1];

  // After any grant the other port gets priority; a forced override sticks if unused.
  always_comb begin
    ptr_d = ptr_q;
    if (|gnt_o)            ptr_d = other_port(win_o);
    else if (prio_force_i) ptr_d = prio_port_i;
  end

  // Priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= PORT0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/memory_data_arbiter.sv
// Shares one single-port synchronous data memory between the CPU LSU (port 0)
// and the debug/DMA loader (port 1): round-robin arbitration, bounded atomic
// lock, and one-cycle read-return routing.
module memory_data_arbiter
  import memory_data_arbiter_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  memory_data_arbiter_if.slave bus,
  output arb_state_t        dbg_state_o,
  output logic              dbg_owner_o,
  output logic [LOCK_W-1:0] dbg_lock_cnt_o
);

  localparam logic [LOCK_W-1:0] LOCK_LIMIT = LOCK_W'(LOCK_MAX);

  arb_state_t          state_q;
  logic                owner_q;
  logic [LOCK_W-1:0]   cnt_q;
  logic                rvalid_q;
  logic                rtag_q;
  logic [MEM_ADDR-1:0] mem_a_q;
  logic [LEN_REG-1:0]  mem_d_q;

  logic [1:0]          req;
  logic [1:0]          mask;
  logic [1:0]          gnt;
  logic                win;
  logic                any_gnt;
  logic                locked;
  logic                force_rel;
  logic                hold_lock;
  logic                win_we;
  logic                win_lock;
  logic [MEM_ADDR-1:0] win_addr;
  logic [LEN_REG-1:0]  win_wdata;
  logic                owner_req;
  logic                owner_lock;

  assign req       = {bus.r1_req, bus.r0_req};
  assign locked    = (state_q == ST_LOCKED);
  // Once the counter reaches the limit the cycle arbitrates as IDLE, non-owner first.
  assign force_rel = locked && (cnt_q >= LOCK_LIMIT);
  assign hold_lock = locked && !force_rel;

  // Eligible ports: none while in reset, only the owner while the lock holds.
  always_comb begin
    mask = 2'b11;
    if (rst)            mask = 2'b00;
    else if (hold_lock) mask = (owner_q == PORT1) ? 2'b10 : 2'b01;
  end

  rr_arbiter2 u_rr (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req),
    .mask_i       (mask),
    .prio_force_i (force_rel),
    .prio_port_i  (other_port(owner_q)),
    .gnt_o        (gnt),
    .win_o        (win)
  );

  assign any_gnt    = |gnt;
  assign win_we     = win ? bus.r1_we    : bus.r0_we;
  assign win_lock   = win ? bus.r1_lock  : bus.r0_lock;
  assign win_addr   = win ? bus.r1_addr  : bus.r0_addr;
  assign win_wdata  = win ? bus.r1_wdata : bus.r0_wdata;
  assign owner_req  = owner_q ? bus.r1_req  : bus.r0_req;
  assign owner_lock = owner_q ? bus.r1_lock : bus.r0_lock;

  // Lock FSM: enter on a locked grant, count every locked cycle, release on
  // unlock, owner drop-out or limit reached.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= PORT0;
      cnt_q   <= '0;
    end else if (hold_lock) begin
      if (!owner_req || !owner_lock) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
      end else begin
        cnt_q   <= cnt_q + 1'b1;
      end
    end else if (any_gnt && win_lock) begin
      state_q <= ST_LOCKED;
      owner_q <= win;
      cnt_q   <= LOCK_W'(1);
    end else begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end
  end

  // Read-return tag: one valid pulse per granted read, steered to the reader.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rtag_q   <= PORT0;
    end else begin
      rvalid_q <= any_gnt && !win_we;
      if (any_gnt && !win_we) rtag_q <= win;
    end
  end

  // Address/data hold registers so the memory pins stay quiet when nobody is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_a_q <= '0;
      mem_d_q <= '0;
    end else if (any_gnt) begin
      mem_a_q <= win_addr;
      mem_d_q <= win_wdata;
    end
  end

  assign bus.mem_A     = any_gnt ? win_addr  : mem_a_q;
  assign bus.mem_D     = any_gnt ? win_wdata : mem_d_q;
  assign bus.mem_W     = any_gnt && win_we;

  assign bus.r0_gnt    = gnt[0];
  assign bus.r1_gnt    = gnt[1];
  assign bus.r0_rvalid = rvalid_q && (rtag_q == PORT0);
  assign bus.r1_rvalid = rvalid_q && (rtag_q == PORT1);
  assign bus.r0_rdata  = bus.mem_Q;
  assign bus.r1_rdata  = bus.mem_Q;

  assign dbg_state_o    = state_q;
  assign dbg_owner_o    = owner_q;
  assign dbg_lock_cnt_o = cnt_q;

endmodule
